// File: rtl/logic_gate_unit.sv
// Single-cycle bitwise logic unit with a valid/ready handshake on both sides.
// The unit also keeps an accumulator for ACC_NAND and a saturating count of accepted operations.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
    logic             r_y_ones;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b,
        input logic [WIDTH-1:0] f_acc
    );
        logic [WIDTH-1:0] f_r;
        f_r = '0;
        case (f_op)
            3'd0:    f_r = f_a & f_b;
            3'd1:    f_r = ~(f_a & f_b);
            3'd2:    f_r = f_a | f_b;
            3'd3:    f_r = ~(f_a | f_b);
            3'd4:    f_r = f_a ^ f_b;
            3'd5:    f_r = ~(f_a ^ f_b);
            3'd6:    f_r = ~f_a;
            default: f_r = ~(f_a & f_acc);
        endcase
        return f_r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] f_cnt);
        return (f_cnt == CNT_MAX) ? f_cnt : f_cnt + CNT_W'(1);
    endfunction

    // Ready depends only on registered state and out_ready, never on a/b/op.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_result = gate_eval(op, a, b, r_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_zero    <= 1'b1;
            r_y_ones    <= 1'b0;
            r_acc       <= ALL_ONES;
            r_op_cnt    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_result;
            r_y_zero    <= (w_result == '0);
            r_y_ones    <= (w_result == ALL_ONES);
            r_acc       <= w_result;
            r_op_cnt    <= sat_inc(r_op_cnt);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_zero    = r_y_zero;
    assign y_ones    = r_y_ones;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: a driver pushes model results on acceptance,
// a monitor pops and compares each result as it is consumed downstream.
module tb_logic_gate_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_ones;
    logic [CNT_W-1:0] op_cnt;

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_zero(y_zero), .y_ones(y_ones), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [31:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: what the unit should hold, tracked at transaction level.
    int   m_acc   = 255;
    int   m_cnt   = 0;
    bit   m_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_op(input int o, input int x, input int z, input int acc);
        int r;
        case (o)
            0: r = x & z;
            1: r = 255 - (x & z);
            2: r = x | z;
            3: r = 255 - (x | z);
            4: r = x ^ z;
            5: r = 255 - (x ^ z);
            6: r = 255 - x;
            default: r = 255 - (x & acc);
        endcase
        return r;
    endfunction

    task automatic step(input logic iv, input int ta, input int tb, input int top, input logic ordy);
        bit exp_rdy;
        int res;
        in_valid  = iv;
        a         = ta[WIDTH-1:0];
        b         = tb[WIDTH-1:0];
        op        = top[2:0];
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !m_valid || ordy;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (iv && exp_rdy) begin
            res   = ref_op(top, ta, tb, m_acc);
            m_acc = res;
            if (m_cnt < CNT_SAT) m_cnt++;
            exp_q.push_back('{y: res[WIDTH-1:0], cnt: m_cnt});
            m_valid = 1;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        m_acc   = 255;
        m_cnt   = 0;
        m_valid = 0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_y_zero", {31'd0, y_zero}, 32'd1);
        check("rst_y_ones", {31'd0, y_ones}, 32'd0);
        check("rst_op_cnt", {28'd0, op_cnt}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: a result is consumed when out_valid and out_ready meet at an edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {24'd0, y}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("y", {24'd0, y}, {24'd0, e.y});
                check("y_zero", {31'd0, y_zero}, {31'd0, (e.y == '0)});
                check("y_ones", {31'd0, y_ones}, {31'd0, (e.y == '1)});
                check("op_cnt", {28'd0, op_cnt}, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset(2);

        // NAND single accept, then drain
        step(1, 8'hF0, 8'hCC, 1, 1);
        check("nand_y", {24'd0, y}, 32'h3F);
        check("nand_cnt", {28'd0, op_cnt}, 32'd1);
        step(0, 0, 0, 0, 1);

        // Backpressure: OR result stalls, AND offer waits for out_ready
        do_reset(1);
        step(1, 8'h0F, 8'hF0, 2, 0);
        step(1, 8'h0F, 8'hF0, 0, 0);
        check("bp_hold_y", {24'd0, y}, 32'hFF);
        check("bp_hold_ones", {31'd0, y_ones}, 32'd1);
        step(1, 8'h0F, 8'hF0, 0, 1);
        check("bp_second_y", {24'd0, y}, 32'h00);
        step(0, 0, 0, 0, 1);

        // ACC_NAND chain from reset
        do_reset(1);
        step(1, 8'h0F, 8'h00, 7, 1);
        step(1, 8'hFF, 8'h00, 7, 1);
        check("accnand_y", {24'd0, y}, 32'h0F);
        step(0, 0, 0, 0, 1);

        // Saturation: 20 back-to-back accepts
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), 1);
        end
        check("sat_cnt", {28'd0, op_cnt}, CNT_SAT);
        step(0, 0, 0, 0, 1);

        // Reset while a stalled result is pending
        do_reset(1);
        step(1, 8'h33, 8'h55, 0, 0);
        step(1, 8'h11, 8'h22, 4, 0);
        do_reset(1);
        step(1, 8'h0F, 8'h00, 7, 1);
        check("rstmid_y", {24'd0, y}, 32'hF0);
        step(0, 0, 0, 0, 1);

        // Random traffic with random backpressure
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                 logic'($urandom_range(0, 3) != 0));
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result bit width (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, sets the width of the accepted-operation counter (legal range 2..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  the upstream stage presents a valid operand set.
REQ-006 in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select, sampled with a/b on acceptance.
REQ-010 out_valid  output  1  y, y_zero and y_ones hold a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 y  output  WIDTH  registered result.
REQ-013 y_zero  output  1  registered flag, 1 when the result is all zeros.
REQ-014 y_ones  output  1  registered flag, 1 when the result is all ones.
REQ-015 op_cnt  output  CNT_W  count of accepted operations, saturating.

Function
REQ-016 Acceptance SHALL occur in cycles where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL equal (~out_valid | out_ready), combinationally.
REQ-018 op encoding SHALL be as follows:
- 0: AND, a&b
- 1: NAND, ~(a&b)
- 2: OR, a|b
- 3: NOR, ~(a|b)
- 4: XOR, a^b
- 5: XNOR, ~(a^b)
- 6: NOT, ~a (b ignored)
- 7: ACC_NAND, ~(a & acc)
REQ-019 acc SHALL be an internal WIDTH-bit register that loads the computed result on every acceptance, for all op values.
REQ-020 Latency SHALL be 1 cycle: the result of an acceptance at edge N SHALL appear on y with out_valid=1 after edge N.
REQ-021 y_zero and y_ones SHALL be registered in the same cycle as y and SHALL be consistent with y.
REQ-022 For WIDTH=1, y_zero SHALL equal ~y and y_ones SHALL equal y.
REQ-023 While out_valid=1 and out_ready=0, y, y_zero, y_ones and acc SHALL hold stable, and no acceptance SHALL occur.
REQ-024 When out_valid=1 and out_ready=1 and a new acceptance occurs in the same cycle, the new result SHALL replace the old one and out_valid SHALL remain 1 (full throughput, one result per cycle).
REQ-025 When out_valid=1, out_ready=1 and no acceptance occurs, out_valid SHALL go to 0 and y SHALL hold its last value.
REQ-026 op_cnt SHALL increment by 1 on each acceptance and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 Inputs a, b and op SHALL be ignored when no acceptance occurs.
REQ-028 The block SHALL contain no combinational path from a, b or op to any output.

Reset
REQ-029 While rst_n=0 at a rising edge, the following SHALL apply:
- out_valid=0, y=0, y_zero=1, y_ones=0, op_cnt=0;
- acc SHALL be set to all ones;
- no acceptance SHALL be recorded, even if in_valid=1.
REQ-030 Reset SHALL take priority over every other event, including reset asserted while out_valid=1 and stalled.
REQ-031 in_ready SHALL read 1 in the first cycle after reset release.

Verification (WIDTH=8 unless stated)
REQ-032 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, y=0x00, y_zero=1, op_cnt=0, in_ready=1.
REQ-033 NAND: a=0xF0, b=0xCC, op=1, one accept -> next cycle y=0x3F, out_valid=1, y_zero=0, y_ones=0, op_cnt=1.
REQ-034 Backpressure: out_ready=0, two consecutive offers (op=2, a=0x0F, b=0xF0, then op=0) -> first gives y=0xFF with y_ones=1; then in_ready=0 and y holds 0xFF; raise out_ready -> second accepted, y=0x00, y_zero=1.
REQ-035 ACC_NAND: after reset, a=0x0F, op=7 -> y=0xF0; then a=0xFF, op=7 -> y=0x0F.
REQ-036 Saturation: CNT_W=4, 20 back-to-back accepts with out_ready=1 -> op_cnt reaches 15 and stays 15, out_valid stays 1 throughout.
REQ-037 Reset mid-operation: stalled result pending (out_valid=1, out_ready=0), assert rst_n=0 for 1 cycle -> out_valid=0, op_cnt=0, then a=0x0F, op=7 -> y=0xF0 (acc restored to 0xFF).
